// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and derived raster constants
// for the display path.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic int span_total(input int visible, input int front,
                                    input int sync_w, input int back);
    return visible + front + sync_w + back;
  endfunction

  localparam int H_TOTAL = span_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL = span_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/clk_enable_div.sv
// Pixel-rate divider: one-cycle tick on the last clock of each pixel period
// and a registered square-wave pixel clock that rises mid-pixel.
module clk_enable_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic pixel_clk
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);
  localparam div_t DIV_HALF = div_t'(CLK_DIV / 2);

  div_t div_cnt;
  div_t div_next;

  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + div_t'(1);
  end

  // Both outputs are decoded from div_next so they are glitch-free flops
  // that line up exactly with div_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      tick      <= 1'b0;
      pixel_clk <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      tick      <= (div_next == DIV_LAST);
      pixel_clk <= (div_next >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, registered sync/blank strobes and a
// once-per-frame update strobe at the start of vertical blanking.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               pixel_ce,
  output logic               pixel_clk,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               sync,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               frame_clk,
  output logic [15:0]        frame_count
);

  localparam coord_t H_LAST     = coord_t'(span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK) - 1);
  localparam coord_t V_LAST     = coord_t'(span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK) - 1);
  localparam coord_t H_ACTIVE   = coord_t'(H_VISIBLE);
  localparam coord_t V_ACTIVE   = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam coord_t V_ACT_LAST = coord_t'(V_VISIBLE - 1);

  logic   tick;
  coord_t h_cnt, v_cnt;
  coord_t h_next, v_next;
  logic   frame_start;

  clk_enable_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (Clk),
    .reset     (Reset),
    .tick      (tick),
    .pixel_clk (pixel_clk)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    h_next      = h_cnt;
    v_next      = v_cnt;
    frame_start = 1'b0;
    if (tick) begin
      if (h_cnt == H_LAST) begin
        h_next      = '0;
        v_next      = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
        frame_start = (v_cnt == V_ACT_LAST);
      end else begin
        h_next = h_cnt + coord_t'(1);
      end
    end
  end

  // Strobes decode the next-state counters so they switch on the same edge
  // as DrawX/DrawY.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_clk   <= 1'b0;
      frame_count <= '0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hs          <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vs          <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      blank       <= (h_next < H_ACTIVE) && (v_next < V_ACTIVE);
      frame_clk   <= frame_start;
      frame_count <= frame_count + {15'd0, frame_start};
    end
  end

  assign pixel_ce = tick;
  assign sync     = 1'b0;
  assign DrawX    = h_cnt;
  assign DrawY    = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default geometry, CLK_DIV=4, and a
// reduced 16x12 raster used for whole-frame scenarios.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic rst_d, rst_4, rst_s;

  logic       pce_d, pclk_d, hs_d, vs_d, blank_d, sync_d, fclk_d;
  logic [9:0] dx_d, dy_d;
  logic [15:0] fcnt_d;
  logic       pce_4, pclk_4, hs_4, vs_4, blank_4, sync_4, fclk_4;
  logic [9:0] dx_4, dy_4;
  logic [15:0] fcnt_4;
  logic       pce_s, pclk_s, hs_s, vs_s, blank_s, sync_s, fclk_s;
  logic [9:0] dx_s, dy_s;
  logic [15:0] fcnt_s;

  vga_timing_gen dut_d (
    .Clk(clk), .Reset(rst_d), .pixel_ce(pce_d), .pixel_clk(pclk_d),
    .hs(hs_d), .vs(vs_d), .blank(blank_d), .sync(sync_d),
    .DrawX(dx_d), .DrawY(dy_d), .frame_clk(fclk_d), .frame_count(fcnt_d)
  );

  vga_timing_gen #(.CLK_DIV(4)) dut_4 (
    .Clk(clk), .Reset(rst_4), .pixel_ce(pce_4), .pixel_clk(pclk_4),
    .hs(hs_4), .vs(vs_4), .blank(blank_4), .sync(sync_4),
    .DrawX(dx_4), .DrawY(dy_4), .frame_clk(fclk_4), .frame_count(fcnt_4)
  );

  // 16 pixels x 12 lines: hs low at x 10..12, vs low at y 8..9, frame = 384 Clk.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
  ) dut_s (
    .Clk(clk), .Reset(rst_s), .pixel_ce(pce_s), .pixel_clk(pclk_s),
    .hs(hs_s), .vs(vs_s), .blank(blank_s), .sync(sync_s),
    .DrawX(dx_s), .DrawY(dy_s), .frame_clk(fclk_s), .frame_count(fcnt_s)
  );

  task automatic test_reset();
    rst_d = 1'b1; rst_4 = 1'b1; rst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pce_d, pclk_d, hs_d, vs_d, blank_d, sync_d, fclk_d} !== 7'b0011100) begin
      failures++;
      $display("FAIL reset_flags_d got=%b want=0011100",
               {pce_d, pclk_d, hs_d, vs_d, blank_d, sync_d, fclk_d});
    end
    checks++;
    if (dx_d !== 10'd0 || dy_d !== 10'd0 || fcnt_d !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts_d got x=%0d y=%0d fc=%0d want 0 0 0", dx_d, dy_d, fcnt_d);
    end
    checks++;
    if ({pce_4, pclk_4, hs_4, vs_4, blank_4, sync_4, fclk_4} !== 7'b0011100 || dx_4 !== 10'd0) begin
      failures++;
      $display("FAIL reset_div4 got flags=%b x=%0d want 0011100 0",
               {pce_4, pclk_4, hs_4, vs_4, blank_4, sync_4, fclk_4}, dx_4);
    end
    rst_d = 1'b0; rst_4 = 1'b0; rst_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (pce_d !== ((i % 2) == 0) || pclk_d !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL release_pattern[%0d] got pce=%b pclk=%b want %0d", i, pce_d, pclk_d, (i % 2) == 0);
      end
      if (i < 4) begin
        checks++;
        if (dx_d !== ((i >= 1) ? 10'(1 + (i - 1) / 2) : 10'd0) ||
            dx_4 !== ((i >= 3) ? 10'd1 : 10'd0)) begin
          failures++;
          $display("FAIL first_tick[%0d] got x_d=%0d x_4=%0d", i, dx_d, dx_4);
        end
      end
    end
  endtask

  task automatic test_hsync();
    logic [9:0] prev_x;
    logic prev_hs, prev_bl;
    bit found;
    int unsigned t0;
    int hs_fall_x, hs_rise_x, bl_fall_x, period;
    found = 1'b0;
    prev_x = dx_d;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dx_d == 10'd0 && prev_x != 10'd0) begin found = 1'b1; break; end
      prev_x = dx_d;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL hsync_line_start timeout");
      return;
    end
    t0 = cyc;
    hs_fall_x = -1; hs_rise_x = -1; bl_fall_x = -1; period = -1;
    prev_hs = hs_d; prev_bl = blank_d; prev_x = dx_d;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (prev_hs && !hs_d) hs_fall_x = int'(dx_d);
      if (!prev_hs && hs_d) hs_rise_x = int'(dx_d);
      if (prev_bl && !blank_d) bl_fall_x = int'(dx_d);
      if (dx_d == 10'd0 && prev_x != 10'd0) begin period = int'(cyc - t0); break; end
      prev_hs = hs_d; prev_bl = blank_d; prev_x = dx_d;
    end
    checks++;
    if (hs_fall_x !== 656) begin failures++; $display("FAIL hs_fall_x got=%0d want=656", hs_fall_x); end
    checks++;
    if (hs_rise_x !== 752) begin failures++; $display("FAIL hs_rise_x got=%0d want=752", hs_rise_x); end
    checks++;
    if (bl_fall_x !== 640) begin failures++; $display("FAIL blank_fall_x got=%0d want=640", bl_fall_x); end
    checks++;
    if (period !== 1600) begin failures++; $display("FAIL line_period got=%0d want=1600", period); end
    checks++;
    if (blank_d !== 1'b1 || hs_d !== 1'b1) begin
      failures++;
      $display("FAIL line_start_strobes got blank=%b hs=%b want 1 1", blank_d, hs_d);
    end
  endtask

  task automatic test_line_wrap();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (dx_d == 10'd799 && dy_d == 10'd5) begin found = 1'b1; break; end
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (dx_d != 10'd799) begin found = 1'b1; break; end
      end
    end
    checks++;
    if (!found || dx_d !== 10'd0 || dy_d !== 10'd6) begin
      failures++;
      $display("FAIL line_wrap got x=%0d y=%0d want 0 6", dx_d, dy_d);
    end
  endtask

  task automatic test_frame_wrap();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dx_s == 10'd15 && dy_s == 10'd11) begin found = 1'b1; break; end
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (dx_s != 10'd15) begin found = 1'b1; break; end
      end
    end
    checks++;
    if (!found || dx_s !== 10'd0 || dy_s !== 10'd0 || blank_s !== 1'b1 || vs_s !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap got x=%0d y=%0d blank=%b vs=%b want 0 0 1 1", dx_s, dy_s, blank_s, vs_s);
    end
  endtask

  task automatic test_frame_strobe();
    int pulses, vs_low, vs_falls, run;
    int unsigned last_t;
    logic prev_f, prev_vs;
    pulses = 0; vs_low = 0; vs_falls = 0; run = 0; last_t = 0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    prev_f = fclk_s; prev_vs = vs_s;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (!vs_s) vs_low++;
      if (prev_vs && !vs_s) vs_falls++;
      if (fclk_s) run++;
      if (fclk_s && !prev_f) begin
        pulses++;
        checks++;
        if (dx_s !== 10'd0 || dy_s !== 10'd6) begin
          failures++;
          $display("FAIL frame_clk_pos[%0d] got x=%0d y=%0d want 0 6", pulses, dx_s, dy_s);
        end
        if (pulses > 1) begin
          checks++;
          if (int'(cyc - last_t) !== 384) begin
            failures++;
            $display("FAIL frame_period got=%0d want=384", int'(cyc - last_t));
          end
        end
        last_t = cyc;
      end
      if (!fclk_s && prev_f) begin
        checks++;
        if (run !== 1) begin failures++; $display("FAIL frame_clk_width got=%0d want=1", run); end
        run = 0;
      end
      prev_f = fclk_s; prev_vs = vs_s;
    end
    checks++;
    if (pulses !== 3) begin failures++; $display("FAIL frame_clk_count got=%0d want=3", pulses); end
    checks++;
    if (fcnt_s !== 16'd3) begin failures++; $display("FAIL frame_count got=%0d want=3", fcnt_s); end
    checks++;
    if (vs_low !== 192 || vs_falls !== 3) begin
      failures++;
      $display("FAIL vs_low got cycles=%0d falls=%0d want 192 3", vs_low, vs_falls);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int highs;
    found = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (dx_s == 10'd5 && dy_s == 10'd3) begin found = 1'b1; break; end
    end
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    checks++;
    if (!found || {pce_s, pclk_s, hs_s, vs_s, blank_s, sync_s, fclk_s} !== 7'b0011100 ||
        dx_s !== 10'd0 || dy_s !== 10'd0 || fcnt_s !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset got flags=%b x=%0d y=%0d fc=%0d want 0011100 0 0 0",
               {pce_s, pclk_s, hs_s, vs_s, blank_s, sync_s, fclk_s}, dx_s, dy_s, fcnt_s);
    end
    found = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (dx_s == 10'd15 && dy_s == 10'd5 && pce_s == 1'b1) begin found = 1'b1; break; end
    end
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    highs = int'(fclk_s);
    checks++;
    if (!found || fclk_s !== 1'b0 || dx_s !== 10'd0 || dy_s !== 10'd0 || fcnt_s !== 16'd0) begin
      failures++;
      $display("FAIL reset_beats_tick got fclk=%b x=%0d y=%0d fc=%0d want 0 0 0 0", fclk_s, dx_s, dy_s, fcnt_s);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      highs += int'(fclk_s);
    end
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL no_partial_frame_clk got=%0d want=0", highs); end
  endtask

  task automatic test_div4();
    bit found;
    logic [9:0] prev_x;
    int unsigned t0;
    int period;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pce_4) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL div4_align timeout"); return; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (pce_4 !== ((i % 4) == 3) || pclk_4 !== ((i % 4) >= 2)) begin
        failures++;
        $display("FAIL div4_pattern[%0d] got pce=%b pclk=%b want %0d %0d",
                 i, pce_4, pclk_4, (i % 4) == 3, (i % 4) >= 2);
      end
    end
    found = 1'b0;
    prev_x = dx_4;
    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      if (dx_4 == 10'd0 && prev_x != 10'd0) begin found = 1'b1; break; end
      prev_x = dx_4;
    end
    t0 = cyc;
    period = -1;
    if (found) begin
      prev_x = dx_4;
      for (int i = 0; i < 3400; i++) begin
        @(negedge clk);
        if (dx_4 == 10'd0 && prev_x != 10'd0) begin period = int'(cyc - t0); break; end
        prev_x = dx_4;
      end
    end
    checks++;
    if (period !== 3200) begin failures++; $display("FAIL div4_line_period got=%0d want=3200", period); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame_wrap();
    test_frame_strobe();
    test_mid_reset();
    test_div4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
